// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_if
// Purpose  : Bundles the fetch unit's instruction-memory request/response
//            channel, the execute-stage redirect, and the decode-side
//            valid/ready output buffer.
// Signals  : imem_req_valid/ready/addr  - word fetch request handshake
//            imem_rsp_valid/data        - in-order fetch response
//            branch_true/branched_pc    - single-cycle redirect from execute
//            if_valid/instr/pc, if_ready - instruction handoff to decode
// Modports : master - the fetch unit; slave - memory, execute and decode side
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        branch_true;
  logic [31:0] branched_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           branch_true, branched_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           branch_true, branched_pc, if_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : RISC-V fetch stage. Owns the PC, issues one word fetch at a time
//            and hands instruction/PC pairs to decode through a one-entry
//            valid/ready buffer. A branch_true pulse retargets the PC and
//            flushes any younger work (buffered or in flight).
// Ports    : clk            - system clock, rising edge
//            rst_n          - asynchronous active-low reset
//            bus (master)   - memory, redirect and decode signals
//            perf_fetch_cnt - instructions loaded into the buffer (opt.)
//            perf_flush_cnt - redirects that discarded work (opt.)
// Options  : define FETCH_PERF_EN to add the two performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_WAIT  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        drop_q, drop_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;

  logic        req_fire;
  logic        rsp_land;
  logic        load;
  logic        unused_ok;

  // The redirect target is word-aligned here, so its low bits are ignored.
  assign unused_ok = ^bus.branched_pc[1:0];

  // Only issue when the buffer is empty or draining this cycle: this is what
  // guarantees a response never lands on an occupied buffer.
  assign bus.imem_req_valid = rst_n & (state_q == S_FETCH) &
                              (~valid_q | bus.if_ready);
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = valid_q;
  assign bus.if_instr       = instr_q;
  assign bus.if_pc          = ipc_q;

  assign req_fire = bus.imem_req_valid & bus.imem_req_ready;
  assign rsp_land = (state_q == S_WAIT) & bus.imem_rsp_valid;
  // A response coinciding with a redirect belongs to the squashed path.
  assign load     = rsp_land & ~drop_q & ~bus.branch_true;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    drop_d   = drop_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;

    if (valid_q && bus.if_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_FETCH: begin
        if (req_fire) begin
          state_d  = S_WAIT;
          req_pc_d = pc_q;
          // A request accepted alongside a redirect fetches the old path.
          drop_d   = bus.branch_true;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          state_d = S_FETCH;
          drop_d  = 1'b0;
        end else if (bus.branch_true) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (load) begin
      valid_d = 1'b1;
      instr_d = bus.imem_rsp_data;
      ipc_d   = req_pc_q;
      pc_d    = req_pc_q + 32'd4;
    end

    if (bus.branch_true) begin
      pc_d    = {bus.branched_pc[31:2], 2'b00};
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      drop_q   <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= 32'h0;
      ipc_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;
  logic        flush_evt;

  // A redirect counts as a flush when it kills a live response or a held
  // buffer entry; at most one count per redirect cycle.
  assign flush_evt = bus.branch_true & ((rsp_land & ~drop_q) | valid_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (load) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (flush_evt) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the RISC-V integer core. Owns the program counter and issues word fetches to instruction memory.
- Presents fetched instruction/PC pairs to decode through a one-entry valid/ready output buffer.
- It is the consumer of the execute stage's branch-resolution outputs (branch_true, branched_pc). A redirect retargets the PC and flushes younger work.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  fetch word address (byte address, [1:0]=0)
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  32  fetched instruction word
- branch_true  in  1  single-cycle redirect pulse from execute
- branched_pc  in  32  redirect target, sampled when branch_true=1
- if_valid  out  1  output buffer holds an instruction
- if_instr  out  32  buffered instruction
- if_pc  out  32  PC of buffered instruction
- if_ready  in  1  decode consumes buffer this cycle

Behaviour:
- Reset (async assert, sync release):
  - pc_q=RESET_PC; state=FETCH; drop=0.
  - if_valid=0, if_instr=0, if_pc=0; imem_req_valid=0 while rst_n=0.
- Interface rules:
  - At most one request outstanding.
  - Response arrives no earlier than the cycle after acceptance; responses return in order.
  - imem_req_addr=pc_q.
- States:
  - FETCH: imem_req_valid=1 iff (if_valid=0 or if_ready=1). When valid&ready, latch req_pc=pc_q and go to WAIT.
  - WAIT: imem_req_valid=0. On imem_rsp_valid:
    - drop=1: discard data, clear drop, go to FETCH.
    - drop=0: load if_instr=imem_rsp_data, if_pc=req_pc, if_valid=1; pc_q=req_pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); go to FETCH.
- Output buffer:
  - if_valid clears on if_valid&if_ready unless reloaded in the same cycle.
  - if_instr and if_pc are stable while if_valid&!if_ready.
  - Issue gating guarantees the buffer is empty when a response lands; no overflow is possible.
- Redirect (branch_true=1) has top priority:
  - pc_q={branched_pc[31:2],2'b00}.
  - if_valid=0 next cycle, regardless of if_ready.
  - FETCH with request accepted this cycle: go to WAIT with drop=1.
  - FETCH without acceptance: stay in FETCH; the next cycle's request uses the new pc_q. Address change while unaccepted is permitted by this memory interface.
  - WAIT with imem_rsp_valid the same cycle: discard the response, go to FETCH, drop=0.
  - WAIT without a response: set drop=1 and stay in WAIT.
  - Redirect while drop=1 already: drop stays 1, pc_q takes the newest target.
- Back-to-back redirects: the last pulse wins.
- Reset asserted mid-WAIT: the pending response is ignored after reset. Memory must also be reset.
- Throughput: one instruction per 2 cycles minimum (request cycle plus response cycle).

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0], incremented on each instruction loaded into the buffer.
  - Adds perf_flush_cnt[31:0], incremented on each branch_true cycle that discards a response or flushes a valid buffer entry.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, memory always ready, rsp one cycle later, if_ready=1 -> addrs 0x0,0x4,0x8; if_pc sequence 0x0,0x4,0x8 with matching data.
- if_ready=0 for 5 cycles after first instr -> if_valid held, if_instr/if_pc stable, no new imem_req_valid until if_ready rises.
- Redirect to 0x0000_0100 while WAIT on addr 0x8; response arrives 2 cycles later -> response discarded, next request addr 0x100, if_pc=0x100.
- Redirect to 0x0000_0203 with if_valid=1 -> buffer flushed next cycle, next fetch addr 0x200.
- Redirect in same cycle as imem_rsp_valid in WAIT -> data never reaches if_instr, next request to target. With FETCH_PERF_EN, perf_flush_cnt increments by 1.
- RESET_PC=32'hFFFF_FFFC, sequential fetch -> second request addr 0x0000_0000.
